// File: rtl/mdu_pkg.sv
// Purpose : shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
// Latency : n/a (declarations and pure functions only).
// Backpr. : n/a. MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU ops in is_md_busy_op().
package mdu_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MTHI  = 4'd4;
    localparam logic [3:0] MDU_MTLO  = 4'd5;
    localparam logic [3:0] MDU_MADD  = 4'd6;
    localparam logic [3:0] MDU_MADDU = 4'd7;
    localparam logic [3:0] MDU_MSUB  = 4'd8;
    localparam logic [3:0] MDU_MSUBU = 4'd9;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // True for ops that occupy the unit for multiple cycles. The D-stage stall
    // unit uses the same function so both sides agree on what makes the unit busy.
    function automatic logic is_md_busy_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purpose : combinational 64-bit result {hi,lo} for mult/div (and madd-class when MDU_MADD_EN).
// Latency : 0 cycles (pure combinational).
// Backpr. : none; ports: op, rs_val, rt_val, current hi/lo in -> result {hi,lo} out.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]          op,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rt_val,
    input  logic [DATA_W-1:0]   hi,
    input  logic [DATA_W-1:0]   lo,
    output logic [2*DATA_W-1:0] result
);

    localparam int W2 = 2 * DATA_W;

    logic [W2-1:0]     acc;
    logic [W2-1:0]     prod_s;
    logic [W2-1:0]     prod_u;
    logic              sgn;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] div_b;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo_s;
    logic [DATA_W-1:0] rem_s;

    always_comb begin
        acc    = {hi, lo};
        // Low 2W bits of the product of sign-extended operands equal the signed product.
        prod_s = {{DATA_W{rs_val[DATA_W-1]}}, rs_val} * {{DATA_W{rt_val[DATA_W-1]}}, rt_val};
        prod_u = {{DATA_W{1'b0}}, rs_val} * {{DATA_W{1'b0}}, rt_val};

        // Signed divide via magnitudes; the most negative value's magnitude is
        // still representable unsigned, so MIN / -1 wraps to MIN with rem 0.
        sgn   = (op == MDU_DIV);
        mag_a = (sgn && rs_val[DATA_W-1]) ? -rs_val : rs_val;
        mag_b = (sgn && rt_val[DATA_W-1]) ? -rt_val : rt_val;
        // Substitute divisor 1 on zero so no X leaks; the result is discarded anyway.
        div_b = (rt_val == '0) ? DATA_W'(1) : mag_b;
        quo   = mag_a / div_b;
        rem   = mag_a % div_b;
        quo_s = (sgn && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1])) ? -quo : quo;
        rem_s = (sgn && rs_val[DATA_W-1]) ? -rem : rem;

        result = acc;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV, MDU_DIVU: begin
                // Divide by zero leaves HI/LO at their current values.
                if (rt_val != '0) result = {rem_s, quo_s};
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  result = acc + prod_s;
            MDU_MADDU: result = acc + prod_u;
            MDU_MSUB:  result = acc - prod_s;
            MDU_MSUBU: result = acc - prod_u;
`endif
            default:   result = acc;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Purpose : EX-stage mult/div unit holding HI/LO; result computed at start, committed after a fixed count.
// Latency : MULT_CYCLES (mult/madd) or DIV_CYCLES (div) busy cycles; mthi/mtlo take effect next edge.
// Backpr. : none; start while busy is ignored (D-stage stall prevents it). Ports: clk, reset (async low),
//           start/op/rs_val/rt_val in; busy/hi/lo out. MDU_MADD_EN enables madd-class ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [2*DATA_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] arith_res;

    mdu_arith #(.DATA_W(DATA_W)) u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (arith_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == MDU_IDLE) begin
            if (start) begin
                if (is_md_busy_op(op)) begin
                    // Result is captured now; the counter only models latency.
                    pend_d  = arith_res;
                    cnt_d   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = MDU_RUN;
                    busy_d  = 1'b1;
                end else if (op == MDU_MTHI) begin
                    hi_d = rs_val;
                end else if (op == MDU_MTLO) begin
                    lo_d = rs_val;
                end
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hi_d    = pend_q[2*DATA_W-1:DATA_W];
                lo_d    = pend_q[DATA_W-1:0];
                state_d = MDU_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose : directed self-checking bench for mult_div_unit with a queue of expected {hi,lo} results.
// Latency : inputs driven 1ns after the rising edge, outputs sampled there too.
// Backpr. : none; MDU_MADD_EN selects the expected madd-class behaviour.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_W(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        op = o; rs_val = v; rt_val = '0; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Issue one op, count busy cycles (bounded), then compare against the scoreboard.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [63:0] exp,
                          input bit inject);
        logic [63:0] e;
        logic [31:0] hi_before;
        int n;
        hi_before = hi;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        exp_q.push_back(exp);
        tick;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            if (inject && n == 2) begin
                op = MDU_MTHI; rs_val = 32'hDEADBEEF; start = 1'b1;
            end
            tick;
            if (inject && n == 2) begin
                start = 1'b0;
                check({tag, " hi held in run"}, {32'b0, hi}, {32'b0, hi_before});
            end
        end
        check({tag, " busy cycles"}, 64'(n), 64'(cyc));
        e = exp_q.pop_front();
        check({tag, " hi:lo"}, {hi, lo}, e);
    endtask

    initial begin
        int rose;
        reset = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        #3;
        check("in reset busy", {63'b0, busy}, 64'd0);
        check("in reset hi:lo", {hi, lo}, 64'd0);
        repeat (2) tick;
        reset = 1'b1;
        tick;
        check("after reset busy", {63'b0, busy}, 64'd0);
        check("after reset hi:lo", {hi, lo}, 64'd0);

        run_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, MC, 64'hFFFFFFFF_FFFFFFFA, 1'b0);
        run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 64'hFFFFFFFE_00000001, 1'b0);
        run_op("div -7/2", MDU_DIV, 32'hFFFFFFF9, 32'd2, DC, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op("div 7/-2", MDU_DIV, 32'd7, 32'hFFFFFFFE, DC, 64'h00000001_FFFFFFFD, 1'b0);
        run_op("div min/-1", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, DC, 64'h00000000_80000000, 1'b0);
        run_op("divu", MDU_DIVU, 32'hFFFFFFFF, 32'd16, DC, 64'h0000000F_0FFFFFFF, 1'b0);
        run_op("divu by 0", MDU_DIVU, 32'd7, 32'd0, DC, 64'h0000000F_0FFFFFFF, 1'b0);

        mt(MDU_MTHI, 32'h12345678);
        check("mthi hi:lo", {hi, lo}, 64'h12345678_0FFFFFFF);
        check("mthi busy", {63'b0, busy}, 64'd0);
        tick;
        check("mthi busy later", {63'b0, busy}, 64'd0);
        mt(MDU_MTLO, 32'hCAFEF00D);
        check("mtlo hi:lo", {hi, lo}, 64'h12345678_CAFEF00D);

        run_op("mult w/ mthi in run", MDU_MULT, 32'd2, 32'd3, MC, 64'h00000000_00000006, 1'b1);

        op = 4'hF; rs_val = 32'd1; rt_val = 32'd1; start = 1'b1;
        tick;
        start = 1'b0;
        check("unknown op busy", {63'b0, busy}, 64'd0);
        check("unknown op hi:lo", {hi, lo}, 64'h00000000_00000006);

        // Reset mid-run: in-flight divide must never write back.
        op = MDU_DIV; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        check("abort busy up", {63'b0, busy}, 64'd1);
        repeat (3) tick;
        #2 reset = 1'b0;
        #1;
        check("abort busy async", {63'b0, busy}, 64'd0);
        check("abort hi:lo async", {hi, lo}, 64'd0);
        tick;
        reset = 1'b1;
        rose = 0;
        repeat (10) begin
            tick;
            if (busy !== 1'b0) rose++;
        end
        check("post-abort busy rises", 64'(rose), 64'd0);
        check("post-abort hi:lo", {hi, lo}, 64'd0);

        mt(MDU_MTHI, 32'h00000000);
        mt(MDU_MTLO, 32'hFFFFFFFF);
        check("madd setup hi:lo", {hi, lo}, 64'h00000000_FFFFFFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", MDU_MADDU, 32'd1, 32'd1, MC, 64'h00000001_00000000, 1'b0);
        run_op("msub", MDU_MSUB, 32'hFFFFFFFF, 32'd2, MC, 64'h00000001_00000002, 1'b0);
`else
        run_op("maddu off", MDU_MADDU, 32'd1, 32'd1, 0, 64'h00000000_FFFFFFFF, 1'b0);
        run_op("msub off", MDU_MSUB, 32'hFFFFFFFF, 32'd2, 0, 64'h00000000_FFFFFFFF, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
